// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video pixel channel: 24-bit RGB data, tuser = start of frame,
// tlast = end of line.
interface axis_video_pattern_gen_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, input tready, output tuser, output tlast);
    modport slave  (input tdata, input tvalid, output tready, input tuser, input tlast);
endinterface

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream raster test-pattern source (solid, colour bars, ramp, checkerboard).
// Pattern inputs are shadowed at each frame start so they only change on frame boundaries.
module axis_video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 12
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            enable,
    input  logic [1:0]                      pattern_sel,
    input  logic [23:0]                     solid_color,
    axis_video_pattern_gen_if.master        m_axis,
    output logic [15:0]                     frame_count,
    output logic                            busy
);
    localparam int               BAR_W    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    function automatic logic [23:0] bar_color_f(input logic [2:0] idx);
        logic [23:0] res;
        case (idx)
            3'd0:    res = 24'hFFFFFF;
            3'd1:    res = 24'hFFFF00;
            3'd2:    res = 24'h00FFFF;
            3'd3:    res = 24'h00FF00;
            3'd4:    res = 24'hFF00FF;
            3'd5:    res = 24'hFF0000;
            3'd6:    res = 24'h0000FF;
            default: res = 24'h000000;
        endcase
        return res;
    endfunction

    function automatic logic [23:0] pixel_f(input logic [1:0]  sel,
                                            input logic [23:0] solid,
                                            input logic [7:0]  ramp,
                                            input logic        chk,
                                            input logic [2:0]  bar);
        logic [23:0] res;
        case (sel)
            2'd0:    res = solid;
            2'd1:    res = bar_color_f(bar);
            2'd2:    res = {ramp, ramp, ramp};
            2'd3:    res = chk ? 24'h000000 : 24'hFFFFFF;
            default: res = 24'h000000;
        endcase
        return res;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   x_r, x_nxt_s, y_r, y_nxt_s;
    logic [CNT_W-1:0]   bar_cnt_r, bar_cnt_nxt_s;
    logic [2:0]         bar_idx_r, bar_idx_nxt_s;
    logic [1:0]         sel_r, sel_nxt_s;
    logic [23:0]        solid_r, solid_nxt_s;
    logic [23:0]        tdata_r, tdata_nxt_s;
    logic               tuser_r, tuser_nxt_s;
    logic               tlast_r, tlast_nxt_s;
    logic               tvalid_r, tvalid_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [15:0]        frame_count_r, fc_nxt_s;

    logic               xfer_s, eol_s, eof_s, frame_done_s, start_s;
    logic [CNT_W-1:0]   x_adv_s, y_adv_s, bar_cnt_adv_s;
    logic [2:0]         bar_idx_adv_s;

    assign xfer_s       = tvalid_r & m_axis.tready;
    assign eol_s        = (x_r == X_LAST);
    assign eof_s        = eol_s & (y_r == Y_LAST);
    assign frame_done_s = (state_r == ST_RUN) & xfer_s & eof_s;
    assign start_s      = ((state_r == ST_IDLE) | frame_done_s) & enable;

    // Bar position tracked with a width counter restarted at each line, avoiding a divider.
    assign x_adv_s       = eol_s ? CNT_ZERO : (x_r + CNT_ONE);
    assign y_adv_s       = eol_s ? (y_r + CNT_ONE) : y_r;
    assign bar_cnt_adv_s = (eol_s | (bar_cnt_r == BAR_LAST)) ? CNT_ZERO : (bar_cnt_r + CNT_ONE);
    assign bar_idx_adv_s = eol_s ? 3'd0 :
                           ((bar_cnt_r == BAR_LAST) ? (bar_idx_r + 3'd1) : bar_idx_r);

    // Next-state and next-pixel selection.
    always_comb begin
        state_nxt_s   = state_r;
        x_nxt_s       = x_r;
        y_nxt_s       = y_r;
        bar_cnt_nxt_s = bar_cnt_r;
        bar_idx_nxt_s = bar_idx_r;
        sel_nxt_s     = sel_r;
        solid_nxt_s   = solid_r;
        tdata_nxt_s   = tdata_r;
        tuser_nxt_s   = tuser_r;
        tlast_nxt_s   = tlast_r;
        tvalid_nxt_s  = tvalid_r;
        busy_nxt_s    = busy_r;
        fc_nxt_s      = frame_count_r;

        if (frame_done_s) begin
            fc_nxt_s = frame_count_r + 16'd1;
        end else begin
            fc_nxt_s = frame_count_r;
        end

        if (start_s) begin
            state_nxt_s   = ST_RUN;
            sel_nxt_s     = pattern_sel;
            solid_nxt_s   = solid_color;
            x_nxt_s       = CNT_ZERO;
            y_nxt_s       = CNT_ZERO;
            bar_cnt_nxt_s = CNT_ZERO;
            bar_idx_nxt_s = 3'd0;
            tdata_nxt_s   = pixel_f(pattern_sel, solid_color, 8'd0, 1'b0, 3'd0);
            tuser_nxt_s   = 1'b1;
            tlast_nxt_s   = (X_LAST == CNT_ZERO);
            tvalid_nxt_s  = 1'b1;
            busy_nxt_s    = 1'b1;
        end else if (frame_done_s) begin
            state_nxt_s   = ST_IDLE;
            x_nxt_s       = CNT_ZERO;
            y_nxt_s       = CNT_ZERO;
            bar_cnt_nxt_s = CNT_ZERO;
            bar_idx_nxt_s = 3'd0;
            tuser_nxt_s   = 1'b0;
            tlast_nxt_s   = 1'b0;
            tvalid_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b0;
        end else if ((state_r == ST_RUN) && xfer_s) begin
            x_nxt_s       = x_adv_s;
            y_nxt_s       = y_adv_s;
            bar_cnt_nxt_s = bar_cnt_adv_s;
            bar_idx_nxt_s = bar_idx_adv_s;
            tdata_nxt_s   = pixel_f(sel_r, solid_r, 8'(x_adv_s),
                                    x_adv_s[3] ^ y_adv_s[3], bar_idx_adv_s);
            tuser_nxt_s   = 1'b0;
            tlast_nxt_s   = (x_adv_s == X_LAST);
        end else begin
            state_nxt_s   = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            x_r           <= CNT_ZERO;
            y_r           <= CNT_ZERO;
            bar_cnt_r     <= CNT_ZERO;
            bar_idx_r     <= 3'd0;
            sel_r         <= 2'd0;
            solid_r       <= 24'h000000;
            tdata_r       <= 24'h000000;
            tuser_r       <= 1'b0;
            tlast_r       <= 1'b0;
            tvalid_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'h0000;
        end else begin
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            bar_cnt_r     <= bar_cnt_nxt_s;
            bar_idx_r     <= bar_idx_nxt_s;
            sel_r         <= sel_nxt_s;
            solid_r       <= solid_nxt_s;
            tdata_r       <= tdata_nxt_s;
            tuser_r       <= tuser_nxt_s;
            tlast_r       <= tlast_nxt_s;
            tvalid_r      <= tvalid_nxt_s;
            busy_r        <= busy_nxt_s;
            frame_count_r <= fc_nxt_s;
        end
    end

    assign m_axis.tdata  = tdata_r;
    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tuser  = tuser_r;
    assign m_axis.tlast  = tlast_r;
    assign frame_count   = frame_count_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench for axis_video_pattern_gen on a 16x4 raster with a
// behavioural pixel model and randomized back-pressure.
module tb_axis_video_pattern_gen;
    localparam int H     = 16;
    localparam int V     = 4;
    localparam int CNT_W = 12;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_color;
    logic [15:0] frame_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fc   = 0;

    logic [23:0] cap_data[$];
    logic        cap_user[$];
    logic        cap_last[$];

    axis_video_pattern_gen_if m_axis();

    axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CNT_W)) dut (
        .ACLK        (clk),
        .ARESETN     (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .m_axis      (m_axis),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference pixel value straight from the pattern definitions.
    function automatic logic [23:0] model_pix(input int sel, input logic [23:0] solid,
                                              input int x, input int y);
        logic [7:0] r;
        case (sel)
            0: return solid;
            1: begin
                case (x / (H / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: begin
                r = 8'(x % 256);
                return {r, r, r};
            end
            default: return ((((x / 8) + (y / 8)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic kick(input bit hold);
        enable = 1'b1;
        @(negedge clk);
        if (!hold) enable = 1'b0;
    endtask

    // Captures transferred beats; also counts outputs that moved while stalled.
    task automatic collect(input int n, input int rdy_pct, input int sel_beat, input int dis_beat,
                           output int cycles, output int unstable, output bit timeout);
        logic [23:0] pd;
        logic        pu, pl;
        bit          stalled;
        stalled = 1'b0; pd = 24'h0; pu = 1'b0; pl = 1'b0;
        cycles = 0; unstable = 0; timeout = 1'b0;
        cap_data.delete(); cap_user.delete(); cap_last.delete();
        while (cap_data.size() < n) begin
            if (cycles >= n * 20 + 100) begin
                timeout = 1'b1;
                break;
            end
            if (cap_data.size() == sel_beat) pattern_sel = 2'd3;
            if (cap_data.size() == dis_beat) enable = 1'b0;
            m_axis.tready = ($urandom_range(99) < rdy_pct);
            if (stalled && (m_axis.tvalid !== 1'b1 || m_axis.tdata !== pd ||
                            m_axis.tuser !== pu || m_axis.tlast !== pl))
                unstable++;
            if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
                cap_data.push_back(m_axis.tdata);
                cap_user.push_back(m_axis.tuser);
                cap_last.push_back(m_axis.tlast);
            end
            stalled = (m_axis.tvalid === 1'b1) && !m_axis.tready;
            pd = m_axis.tdata; pu = m_axis.tuser; pl = m_axis.tlast;
            @(negedge clk);
            cycles++;
        end
        m_axis.tready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_color = 24'h0;
        m_axis.tready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got v/u/l/busy=%b required 0000",
                               {m_axis.tvalid, m_axis.tuser, m_axis.tlast, busy});
        end
        n_checks++;
        if (m_axis.tdata !== 24'h0 || frame_count !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got tdata=%h fc=%h required 0/0",
                               m_axis.tdata, frame_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_axis.tvalid !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_enable: got tvalid=%b required 0", m_axis.tvalid);
        end
    endtask

    task automatic test_bars;
        int cyc, unst; bit to;
        pattern_sel = 2'd1; solid_color = 24'($urandom);
        @(negedge clk);
        n_checks++;
        if (m_axis.tvalid !== 1'b0) begin
            n_fail++; $display("FAIL bars_pre: got tvalid=%b required 0", m_axis.tvalid);
        end
        kick(1'b0);
        n_checks++;
        if ({m_axis.tvalid, m_axis.tuser, busy} !== 3'b111) begin
            n_fail++; $display("FAIL bars_latency: got v/u/busy=%b required 111",
                               {m_axis.tvalid, m_axis.tuser, busy});
        end
        pattern_sel = 2'($urandom); solid_color = 24'($urandom);
        collect(FRAME, 100, -1, -1, cyc, unst, to);
        n_checks++;
        if (to || cap_data.size() != FRAME || cyc != FRAME) begin
            n_fail++; $display("FAIL bars_count: got %0d beats in %0d cycles required %0d",
                               cap_data.size(), cyc, FRAME);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== model_pix(1, 24'h0, i % H, i / H) ||
                cap_user[i] !== (i == 0) || cap_last[i] !== ((i % H) == H - 1)) begin
                n_fail++; $display("FAIL bars_beat %0d: got %h/%b/%b required %h/%b/%b", i,
                                   cap_data[i], cap_user[i], cap_last[i],
                                   model_pix(1, 24'h0, i % H, i / H), i == 0, (i % H) == H - 1);
            end
        end
        exp_fc++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_axis.tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'(exp_fc)) begin
            n_fail++; $display("FAIL bars_end: got v=%b busy=%b fc=%0d required 0/0/%0d",
                               m_axis.tvalid, busy, frame_count, exp_fc);
        end
    endtask

    task automatic test_backpressure;
        int cyc, unst; bit to;
        pattern_sel = 2'd2;
        kick(1'b0);
        collect(FRAME, 50, -1, -1, cyc, unst, to);
        n_checks++;
        if (to || cap_data.size() != FRAME) begin
            n_fail++; $display("FAIL bp_count: got %0d beats required %0d", cap_data.size(), FRAME);
        end
        n_checks++;
        if (unst != 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles required 0", unst);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== model_pix(2, 24'h0, i % H, i / H) ||
                cap_user[i] !== (i == 0) || cap_last[i] !== ((i % H) == H - 1)) begin
                n_fail++; $display("FAIL bp_beat %0d: got %h/%b/%b required %h", i,
                                   cap_data[i], cap_user[i], cap_last[i],
                                   model_pix(2, 24'h0, i % H, i / H));
            end
        end
        exp_fc++;
        n_checks++;
        if (frame_count !== 16'(exp_fc) || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_end: got fc=%0d busy=%b required %0d/0",
                               frame_count, busy, exp_fc);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, unst; bit to;
        pattern_sel = 2'd0; solid_color = 24'h123456;
        kick(1'b1);
        collect(3 * FRAME, 100, -1, 2 * FRAME + 2, cyc, unst, to);
        n_checks++;
        if (to || cap_data.size() != 3 * FRAME || cyc != 3 * FRAME) begin
            n_fail++; $display("FAIL b2b_count: got %0d beats in %0d cycles required %0d",
                               cap_data.size(), cyc, 3 * FRAME);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== 24'h123456 || cap_user[i] !== ((i % FRAME) == 0) ||
                cap_last[i] !== ((i % H) == H - 1)) begin
                n_fail++; $display("FAIL b2b_beat %0d: got %h/%b/%b required 123456", i,
                                   cap_data[i], cap_user[i], cap_last[i]);
            end
        end
        exp_fc += 3;
        n_checks++;
        if (frame_count !== 16'(exp_fc) || m_axis.tvalid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got fc=%0d v=%b required %0d/0",
                               frame_count, m_axis.tvalid, exp_fc);
        end
    endtask

    task automatic test_pattern_switch;
        int cyc, unst; bit to;
        logic [23:0] sc;
        sc = 24'($urandom);
        pattern_sel = 2'd0; solid_color = sc;
        kick(1'b1);
        collect(2 * FRAME, 100, 20, FRAME + 6, cyc, unst, to);
        n_checks++;
        if (to || cap_data.size() != 2 * FRAME) begin
            n_fail++; $display("FAIL sw_count: got %0d beats required %0d",
                               cap_data.size(), 2 * FRAME);
        end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== ((i < FRAME) ? sc : model_pix(3, sc, i % H, (i / H) % V))) begin
                n_fail++; $display("FAIL sw_beat %0d: got %h required %h", i, cap_data[i],
                                   (i < FRAME) ? sc : model_pix(3, sc, i % H, (i / H) % V));
            end
        end
        n_checks++;
        if (cap_data.size() == 2 * FRAME &&
            (cap_data[FRAME] !== 24'hFFFFFF || cap_data[FRAME + 8] !== 24'h000000 ||
             cap_data[FRAME + 3 * H] !== 24'hFFFFFF)) begin
            n_fail++; $display("FAIL sw_spots: got %h %h %h required FFFFFF 000000 FFFFFF",
                               cap_data[FRAME], cap_data[FRAME + 8], cap_data[FRAME + 3 * H]);
        end
        exp_fc += 2;
        n_checks++;
        if (frame_count !== 16'(exp_fc)) begin
            n_fail++; $display("FAIL sw_fc: got %0d required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_midframe_reset;
        int cyc, unst; bit to;
        pattern_sel = 2'd1;
        kick(1'b1);
        collect(30, 100, -1, -1, cyc, unst, to);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 0;
        n_checks++;
        if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast, busy} !== 4'b0000 ||
            frame_count !== 16'h0 || m_axis.tdata !== 24'h0) begin
            n_fail++; $display("FAIL rst_mid: got v/u/l/busy=%b fc=%h tdata=%h required 0",
                               {m_axis.tvalid, m_axis.tuser, m_axis.tlast, busy},
                               frame_count, m_axis.tdata);
        end
        @(negedge clk);
        n_checks++;
        if ({m_axis.tvalid, m_axis.tuser, busy} !== 3'b111 || m_axis.tdata !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL rst_restart: got v/u/busy=%b tdata=%h required 111 FFFFFF",
                               {m_axis.tvalid, m_axis.tuser, busy}, m_axis.tdata);
        end
        collect(FRAME, 100, -1, 0, cyc, unst, to);
        for (int i = 0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== model_pix(1, 24'h0, i % H, i / H) || cap_user[i] !== (i == 0)) begin
                n_fail++; $display("FAIL rst_beat %0d: got %h/%b required %h", i,
                                   cap_data[i], cap_user[i], model_pix(1, 24'h0, i % H, i / H));
            end
        end
        exp_fc++;
        n_checks++;
        if (to || frame_count !== 16'(exp_fc)) begin
            n_fail++; $display("FAIL rst_fc: got %0d required %0d", frame_count, exp_fc);
        end
    endtask

    task automatic test_fc_wrap;
        int cyc, unst; bit to;
        force dut.frame_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_r;
        n_checks++;
        if (frame_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_deposit: got %h required FFFF", frame_count);
        end
        pattern_sel = 2'd3;
        kick(1'b0);
        collect(FRAME, 30 + int'($urandom_range(70)), -1, -1, cyc, unst, to);
        for (int i = 0; i < cap_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== model_pix(3, 24'h0, i % H, i / H)) begin
                n_fail++; $display("FAIL wrap_beat %0d: got %h required %h", i,
                                   cap_data[i], model_pix(3, 24'h0, i % H, i / H));
            end
        end
        n_checks++;
        if (to || frame_count !== 16'h0000 || unst != 0) begin
            n_fail++; $display("FAIL wrap_fc: got %h (unstable %0d) required 0000",
                               frame_count, unst);
        end
    endtask

    initial begin
        m_axis.tready = 1'b1;
        test_reset();
        test_bars();
        test_backpressure();
        test_back_to_back();
        test_pattern_switch();
        test_midframe_reset();
        test_fc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_video_pattern_gen.md
Name: axis_video_pattern_gen

Overview:
AXI4-Stream video source that produces raster frames of RGB888 pixels. It feeds the s_axis input of AXIS2VGA directly and is used for bring-up and for board self-test without a camera.
- Frame framing follows AXI4-Stream video convention: TUSER marks start of frame (SOF), TLAST marks end of line (EOL).
- Pattern select, solid colour and enable are driven from software-written registers held outside this block.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8 and at least 8.
V_ACTIVE, 480, active lines per frame; at least 1.
CNT_W, 12, width of the x/y counters; 2^CNT_W must be greater than max(H_ACTIVE, V_ACTIVE).

Ports:
ACLK  in  1  system clock; all logic on rising edge.
ARESETN  in  1  synchronous active-low reset.
enable  in  1  level; frames are generated while high.
pattern_sel  in  2  0 solid, 1 colour bars, 2 horizontal ramp, 3 checkerboard.
solid_color  in  24  {R,G,B} value used by pattern 0.
M_AXIS_TDATA  out  24  pixel {R[23:16],G[15:8],B[7:0]}.
M_AXIS_TVALID  out  1  pixel valid.
M_AXIS_TREADY  in  1  downstream ready.
M_AXIS_TUSER  out  1  SOF; high only on pixel (0,0).
M_AXIS_TLAST  out  1  EOL; high on x = H_ACTIVE-1.
frame_count  out  16  completed-frame counter.
busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (ARESETN low at a rising edge):
  - State goes to IDLE.
  - TVALID, TUSER, TLAST, busy = 0; TDATA = 0; frame_count = 0; x = y = 0.
  - Reset has priority over everything, including mid-frame. The partial frame is abandoned and no TLAST is forced.
- FSM, two states:
  - IDLE to RUN: on a rising edge with enable=1. In the same edge the block latches pattern_sel and solid_color into shadow registers, loads pixel (0,0) into the output registers, and sets TVALID=1, TUSER=1, busy=1. Latency from enable sampled high to TVALID high is 1 cycle.
  - RUN: a pixel transfers when TVALID & TREADY. On a transfer, x/y advance and the next pixel is registered onto TDATA/TUSER/TLAST in that same edge. Back-to-back throughput is 1 pixel per clock.
  - RUN, no transfer: TDATA, TUSER, TLAST and TVALID hold stable. TVALID never drops without a handshake.
  - x advance: x increments. At x = H_ACTIVE-1, x wraps to 0 and y increments.
  - Last pixel of frame (x = H_ACTIVE-1, y = V_ACTIVE-1) transferred:
    - frame_count increments, wrapping 0xFFFF to 0x0000.
    - If enable=1, the next frame starts in the same edge: pixel (0,0) with TUSER=1, shadow registers re-latched, no bubble.
    - If enable=0, go to IDLE with TVALID=0 and busy=0.
- Enable deasserted mid-frame: the current frame completes in full, because enable is only sampled at frame boundaries.
- Pattern inputs are used only through the shadow registers, so a change mid-frame takes effect at the next frame.
- Patterns, as a function of the pixel's own (x, y):
  - 0 solid: TDATA = shadow solid_color.
  - 1 bars: 8 vertical bars, each H_ACTIVE/8 wide, ordered white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
    - Bar index comes from a bar-width counter that resets at each line start. No divider is used.
  - 2 ramp: R = G = B = x[7:0]; the ramp wraps every 256 pixels.
  - 3 checker: 8x8 squares. FFFFFF when x[3]^y[3] = 0, else 000000.
- TUSER and TLAST both high is legal only when H_ACTIVE=1; this is excluded by the parameter rule.
- frame_count and busy are registered and change only on the edges described above.

Test Plan:
- H_ACTIVE=16, V_ACTIVE=4, pattern 1, TREADY tied 1, enable pulsed high for 1 cycle:
  - TVALID rises 1 cycle after enable is sampled; exactly 64 beats follow.
  - TUSER on beat 0 only; TLAST on beats 15, 31, 47, 63.
  - Line data is FFFFFF x2, FFFF00 x2, ..., 000000 x2.
  - IDLE is entered after beat 63; frame_count = 1.
- Same config, TREADY toggled pseudo-randomly (about 50%), pattern 2:
  - Beat sequence is identical to a TREADY=1 run; x ramps 00..0F on each line.
  - TDATA/TUSER/TLAST/TVALID are stable on every cycle with TVALID=1, TREADY=0.
- enable held high for 3 frames, pattern 0, solid_color=123456:
  - 192 beats, all 123456, with no bubble between frames.
  - TUSER on beats 0, 64 and 128; frame_count = 3.
- pattern_sel switched 0 to 3 at beat 20 of frame 1:
  - Frame 1 stays solid throughout.
  - Frame 2 is a checkerboard: pixel (8,0) = 000000, (0,0) = FFFFFF, (8,8) not present (V=4), (0,0) of line 3 = FFFFFF.
- ARESETN pulled low for 1 cycle at beat 30 of a frame:
  - Next edge: TVALID=0, busy=0, frame_count=0.
  - With enable still high, a fresh frame starts 1 cycle after reset is released, beginning with TUSER=1 on pixel (0,0).
- frame_count wrap: force the counter to FFFF via a hierarchical deposit, complete one frame -> frame_count = 0000.
